// File: rtl/result_bcd_conv_pkg.sv
// Shared types and constants for the binary-to-BCD result converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum and the double-dabble digit correction constants.
package result_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // A work digit at or above the threshold gets the offset added before each shift.
    // After the shift it then carries correctly into the next decade.
    localparam logic [3:0] BCD_THRESH = 4'd5;
    localparam logic [3:0] BCD_OFFSET = 4'd3;

endpackage

// File: rtl/result_bcd_conv_if.sv
// Handshake/result bundle between the multiplier and the BCD converter.
// Latency: n/a (wiring only).
// Backpressure: none; the producer watches busy, and strobes sent while busy are dropped.
//
// Signals: valid/Y (product strobe and value), busy, done, sign, bcd (packed BCD, units digit in [3:0]).
// Modports: master = multiplier side, slave = converter side.
interface result_bcd_conv_if #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) ();
    logic                  valid;
    logic [W-1:0]          Y;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output valid, Y, input busy, done, sign, bcd);
    modport slave  (input valid, Y, output busy, done, sign, bcd);
endinterface

// File: rtl/result_bcd_conv_add3.sv
// Single-digit double-dabble correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: din (work digit), dout (corrected digit).
module bcd_add3
    import result_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_THRESH) begin
            dout = din + BCD_OFFSET;
        end
    end

endmodule

// File: rtl/result_bcd_conv.sv
// Converts a signed product into sign + packed-BCD magnitude using serial double dabble.
// Latency: done pulses W+1 rising edges after the edge that accepts valid.
// Backpressure: none; valid is only accepted in IDLE, and strobes while busy are dropped.
//
// Ports: clk, rst (async, active-high), bus (slave side: valid, Y in; busy, done, sign, bcd out).
module result_bcd_conv
    import result_bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    result_bcd_conv_if.slave  bus
);

    localparam int                CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [W-1:0]          mag;
    logic [4*DIGITS-1:0]   work;
    logic [4*DIGITS-1:0]   work_adj;
    logic                  sign_cap;
    logic                  sign_out;
    logic [4*DIGITS-1:0]   bcd_out;

    // Per-digit correction applied to the whole work register before each shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work[4*i +: 4]),
            .dout (work_adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CONV performs W shift steps while cnt counts 0..W-1.
    // The cycle with cnt == W only publishes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.valid) state_nxt = CONV;
            CONV:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mag      <= '0;
            work     <= '0;
            sign_cap <= 1'b0;
            sign_out <= 1'b0;
            bcd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid) begin
                        // Plain W-bit negation: the most negative input maps to 2^(W-1).
                        mag      <= bus.Y[W-1] ? (~bus.Y) + W'(1) : bus.Y;
                        sign_cap <= bus.Y[W-1];
                        work     <= '0;
                        cnt      <= '0;
                    end
                end
                CONV: begin
                    if (cnt != CNT_LAST) begin
                        {work, mag} <= {work_adj, mag} << 1;
                        cnt         <= cnt + CNT_W'(1);
                    end else begin
                        bcd_out  <= work;
                        sign_out <= sign_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sign = sign_out;
    assign bus.bcd  = bcd_out;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Directed bench for result_bcd_conv: hand-computed vectors, latency, overlap and reset cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_result_bcd_conv;

    localparam int W      = 16;
    localparam int DIGITS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    logic [19:0] prev_bcd  = '0;
    logic        prev_sign = 1'b0;

    result_bcd_conv_if #(.W(W), .DIGITS(DIGITS)) bus ();

    result_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one valid strobe; returns just after the sampling edge.
    task automatic start(input logic [15:0] y);
        @(negedge clk);
        bus.Y     = y;
        bus.valid = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.Y     = ~y;
    endtask

    // Follows edges 1..18 after the sampling edge and checks done timing and results.
    task automatic wait_done(input string tag, input logic exp_sign, input logic [19:0] exp_bcd);
        int early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) early++;
            if (k == 10) begin
                chk({tag, "_hold_bcd"}, 32'(bus.bcd), 32'(prev_bcd));
                chk({tag, "_hold_sign"}, 32'(bus.sign), 32'(prev_sign));
            end
        end
        chk({tag, "_early_done"}, early, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_busy_done"}, 32'(bus.busy), 1);
        chk({tag, "_sign"}, 32'(bus.sign), 32'(exp_sign));
        chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(bus.done), 0);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
        prev_bcd  = exp_bcd;
        prev_sign = exp_sign;
    endtask

    initial begin
        int pulses;
        int done_at;
        bus.valid = 1'b0;
        bus.Y     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sign", 32'(bus.sign), 0);
        chk("rst_bcd", 32'(bus.bcd), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("release_no_start", 32'(bus.busy), 0);

        start(16'h0000); wait_done("zero", 1'b0, 20'h00000);
        start(16'h4000); wait_done("p16384", 1'b0, 20'h16384);
        start(16'hC080); wait_done("n16256", 1'b1, 20'h16256);
        start(16'h8000); wait_done("n32768", 1'b1, 20'h32768);

        // Valid during CONV is dropped; Y changes after acceptance do not matter.
        start(16'h0007);
        pulses  = 0;
        done_at = 0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 5) begin
                bus.Y     = 16'h1234;
                bus.valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (k == 5) bus.valid = 1'b0;
            if (bus.done) begin
                pulses++;
                done_at = k;
            end
            if (k == 17) begin
                chk("ovl_sign", 32'(bus.sign), 0);
                chk("ovl_bcd", 32'(bus.bcd), 32'h00007);
            end
        end
        chk("ovl_pulses", pulses, 1);
        chk("ovl_done_edge", done_at, 17);
        chk("ovl_idle", 32'(bus.busy), 0);
        prev_bcd  = 20'h00007;
        prev_sign = 1'b0;

        // Accepted in the IDLE cycle right after DONE.
        start(16'h1234); wait_done("b2b", 1'b0, 20'h04660);

        // Async reset at CONV cycle 8 aborts without a done pulse.
        start(16'h7FFF);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_sign", 32'(bus.sign), 0);
        chk("abort_bcd", 32'(bus.bcd), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        prev_bcd  = 20'h00000;
        prev_sign = 1'b0;

        start(16'hFFFF); wait_done("neg1", 1'b1, 20'h00001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
